max_priority_queue_heap: RTL and testbench

Parametrised successor to the non-pipelined max priority queue. It is a binary-heap priority queue with key+tag entries, selectable max/min ordering, and a REPLACE (pop-and-push) operation. Sifting is done by a multi-cycle FSM with a ready/valid command interface. It sits between a producer issuing PUSH/POP/REPLACE commands and a consumer that reads the current top entry.

---
 rtl/max_priority_queue_heap.sv | 212 +++++++++++++++++++++
 tb/tb_max_priority_queue_heap.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_priority_queue_heap.sv
// Binary-heap priority queue (max or min ordering) with key+tag entries and a
// multi-cycle sift FSM. Define PQ_HWM_EN to add the high_water output.
module max_priority_queue_heap #(
  parameter int KEY_WIDTH = 8,
  parameter int TAG_WIDTH = 4,
  parameter int PQ_DEPTH  = 8,
  parameter int MIN_MODE  = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [KEY_WIDTH-1:0]             data_in,
  input  logic [TAG_WIDTH-1:0]             tag_in,
  input  logic                             valid_in,
  input  logic [1:0]                       op,
  input  logic                             ready_in,
  output logic                             ready_out,
  output logic [KEY_WIDTH-1:0]             pq_out,
  output logic [TAG_WIDTH-1:0]             tag_out,
  output logic                             valid_out,
  output logic [$clog2(PQ_DEPTH+1)-1:0]    count,
  output logic                             full,
  output logic                             empty,
  output logic                             err
`ifdef PQ_HWM_EN
  ,
  output logic [$clog2(PQ_DEPTH+1)-1:0]    high_water
`endif
);

  localparam int CW = $clog2(PQ_DEPTH+1);
  localparam int IW = $clog2(PQ_DEPTH);

  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  // Command handshake: a command is taken on a rising edge when valid_in and
  // ready_out are both high; POP and REPLACE additionally need ready_in high.
  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [CW-1:0]        cnt, cnt_nxt, cnt_m1;
  logic                 err_nxt;

  logic [KEY_WIDTH-1:0] heap_key [PQ_DEPTH];
  logic [TAG_WIDTH-1:0] heap_tag [PQ_DEPTH];

  logic                 wr_en;
  logic [IW-1:0]        wr_idx;
  logic [KEY_WIDTH-1:0] wr_key;
  logic [TAG_WIDTH-1:0] wr_tag;
  logic                 swap_en;
  logic [IW-1:0]        swap_a, swap_b;

  logic                 is_empty, is_full, accept, push_like;
  logic [IW-1:0]        ins_idx, last_idx, parent_idx;
  logic [IW+1:0]        l_full, r_full, cnt_ext;
  logic                 has_l, has_r;
  logic [IW-1:0]        l_idx, r_idx, child_idx;

  function automatic logic higher(input logic [KEY_WIDTH-1:0] a,
                                  input logic [KEY_WIDTH-1:0] b);
    if (MIN_MODE != 0) return a < b;
    else               return a > b;
  endfunction

  assign is_empty  = (cnt == '0);
  assign is_full   = (cnt == CW'(PQ_DEPTH));
  assign cnt_m1    = cnt - CW'(1);
  assign ins_idx   = cnt[IW-1:0];
  assign last_idx  = cnt_m1[IW-1:0];
  assign accept    = valid_in && ready_out &&
                     ((op == OP_PUSH) || (((op == OP_POP) || (op == OP_REPLACE)) && ready_in));
  // REPLACE into an empty queue is treated exactly as a PUSH.
  assign push_like = (op == OP_PUSH) || ((op == OP_REPLACE) && is_empty);

  assign parent_idx = (idx - IW'(1)) >> 1;

  // Children indices are formed two bits wider so they never wrap before the
  // bound check against the current count.
  assign l_full    = {1'b0, idx, 1'b1};
  assign r_full    = l_full + (IW+2)'(1);
  assign cnt_ext   = (IW+2)'(cnt);
  assign has_l     = (l_full < cnt_ext);
  assign has_r     = (r_full < cnt_ext);
  assign l_idx     = has_l ? l_full[IW-1:0] : '0;
  assign r_idx     = has_r ? r_full[IW-1:0] : '0;
  assign child_idx = (has_r && higher(heap_key[r_idx], heap_key[l_idx])) ? r_idx : l_idx;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_key    = data_in;
    wr_tag    = tag_in;
    swap_en   = 1'b0;
    swap_a    = '0;
    swap_b    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (push_like) begin
            if (is_full) begin
              err_nxt = 1'b1;
            end else begin
              wr_en   = 1'b1;
              wr_idx  = ins_idx;
              cnt_nxt = cnt + CW'(1);
              if (!is_empty) begin
                state_nxt = SIFT_UP;
                idx_nxt   = ins_idx;
              end
            end
          end else if (op == OP_POP) begin
            if (is_empty) begin
              err_nxt = 1'b1;
            end else if (cnt == CW'(1)) begin
              cnt_nxt = '0;
            end else begin
              // Last leaf moves to the root, then sinks.
              wr_en     = 1'b1;
              wr_idx    = '0;
              wr_key    = heap_key[last_idx];
              wr_tag    = heap_tag[last_idx];
              cnt_nxt   = cnt_m1;
              state_nxt = SIFT_DOWN;
              idx_nxt   = '0;
            end
          end else begin
            wr_en     = 1'b1;
            wr_idx    = '0;
            state_nxt = SIFT_DOWN;
            idx_nxt   = '0;
          end
        end
      end
      SIFT_UP: begin
        if (idx == '0) begin
          state_nxt = IDLE;
        end else if (higher(heap_key[idx], heap_key[parent_idx])) begin
          swap_en = 1'b1;
          swap_a  = idx;
          swap_b  = parent_idx;
          idx_nxt = parent_idx;
        end else begin
          state_nxt = IDLE;
        end
      end
      SIFT_DOWN: begin
        if (has_l && higher(heap_key[child_idx], heap_key[idx])) begin
          swap_en = 1'b1;
          swap_a  = idx;
          swap_b  = child_idx;
          idx_nxt = child_idx;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Storage needs no reset: count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      heap_key[wr_idx] <= wr_key;
      heap_tag[wr_idx] <= wr_tag;
    end else if (swap_en) begin
      heap_key[swap_a] <= heap_key[swap_b];
      heap_key[swap_b] <= heap_key[swap_a];
      heap_tag[swap_a] <= heap_tag[swap_b];
      heap_tag[swap_b] <= heap_tag[swap_a];
    end
  end

`ifdef PQ_HWM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_water <= '0;
    end else if (cnt_nxt > high_water) begin
      high_water <= cnt_nxt;
    end
  end
`endif

  assign ready_out = (state == IDLE);
  assign valid_out = ready_out && !is_empty;
  assign pq_out    = valid_out ? heap_key[0] : '0;
  assign tag_out   = valid_out ? heap_tag[0] : '0;
  assign count     = cnt;
  assign full      = is_full;
  assign empty     = is_empty;

endmodule

// File: tb/tb_max_priority_queue_heap.sv
// Bench for max_priority_queue_heap: a max-mode and a min-mode instance checked
// every cycle against a multiset model, plus directed literal expectations.
module tb_max_priority_queue_heap;

  localparam int KW = 8;
  localparam int TW = 4;
  localparam int D  = 8;
  localparam int CW = $clog2(D+1);

  localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [KW-1:0] a_data, b_data;
  logic [TW-1:0] a_tagi, b_tagi;
  logic          a_vin, b_vin, a_rin, b_rin;
  logic [1:0]    a_op, b_op;
  logic          a_rout, a_vout, a_full, a_empty, a_err;
  logic          b_rout, b_vout, b_full, b_empty, b_err;
  logic [KW-1:0] a_pq, b_pq;
  logic [TW-1:0] a_tago, b_tago;
  logic [CW-1:0] a_cnt, b_cnt, a_hw, b_hw;

  max_priority_queue_heap #(.KEY_WIDTH(KW), .TAG_WIDTH(TW), .PQ_DEPTH(D), .MIN_MODE(0)) u_max (
    .clk(clk), .reset(reset), .data_in(a_data), .tag_in(a_tagi), .valid_in(a_vin),
    .op(a_op), .ready_in(a_rin), .ready_out(a_rout), .pq_out(a_pq), .tag_out(a_tago),
    .valid_out(a_vout), .count(a_cnt), .full(a_full), .empty(a_empty), .err(a_err)
`ifdef PQ_HWM_EN
    , .high_water(a_hw)
`endif
  );

  max_priority_queue_heap #(.KEY_WIDTH(KW), .TAG_WIDTH(TW), .PQ_DEPTH(D), .MIN_MODE(1)) u_min (
    .clk(clk), .reset(reset), .data_in(b_data), .tag_in(b_tagi), .valid_in(b_vin),
    .op(b_op), .ready_in(b_rin), .ready_out(b_rout), .pq_out(b_pq), .tag_out(b_tago),
    .valid_out(b_vout), .count(b_cnt), .full(b_full), .empty(b_empty), .err(b_err)
`ifdef PQ_HWM_EN
    , .high_water(b_hw)
`endif
  );

`ifndef PQ_HWM_EN
  assign a_hw = '0;
  assign b_hw = '0;
`endif

  // model: unordered multiset of {key, tag} per instance
  logic [KW+TW-1:0] mq0[$], mq1[$];
  int  hw0 = 0, hw1 = 0;
  bit  experr0 = 0, experr1 = 0;
  int  n_cmp = 0, n_bad = 0;

  logic [7:0] fill_k [8] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};
  logic [7:0] drain_k [8] = '{8'h8D, 8'h81, 8'h65, 8'h63, 8'h24, 8'h12, 8'h0D, 8'h09};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int msize(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [KW+TW-1:0] mget(input int d, input int i);
    return (d == 0) ? mq0[i] : mq1[i];
  endfunction

  // Best key in the model: largest for the max instance, smallest for min.
  function automatic logic [KW-1:0] top_key(input int d);
    logic [KW+TW-1:0] e;
    logic [KW-1:0]    k, best;
    best = '0;
    for (int i = 0; i < msize(d); i++) begin
      e = mget(d, i);
      k = e[KW+TW-1:TW];
      if (i == 0 || ((d == 0) ? (k > best) : (k < best))) best = k;
    end
    return best;
  endfunction

  function automatic bit has_pair(input int d, input logic [KW-1:0] k, input logic [TW-1:0] t);
    for (int i = 0; i < msize(d); i++)
      if (mget(d, i) === {k, t}) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mremove(input int d, input logic [KW-1:0] k, input logic [TW-1:0] t);
    int pos;
    logic [KW+TW-1:0] e;
    pos = -1;
    for (int i = 0; i < msize(d); i++)
      if (pos < 0 && mget(d, i) === {k, t}) pos = i;
    if (pos < 0)
      for (int i = 0; i < msize(d); i++) begin
        e = mget(d, i);
        if (pos < 0 && e[KW+TW-1:TW] == top_key(d)) pos = i;
      end
    if (pos >= 0) begin
      if (d == 0) mq0.delete(pos);
      else        mq1.delete(pos);
    end
  endfunction

  function automatic void mpush(input int d, input logic [KW-1:0] k, input logic [TW-1:0] t);
    if (d == 0) begin
      mq0.push_back({k, t});
      if (mq0.size() > hw0) hw0 = mq0.size();
    end else begin
      mq1.push_back({k, t});
      if (mq1.size() > hw1) hw1 = mq1.size();
    end
  endfunction

  function automatic void set_err(input int d);
    if (d == 0) experr0 = 1'b1;
    else        experr1 = 1'b1;
  endfunction

  // driver tasks (called #1 after a rising edge)
  task automatic wait_idle(input int d);
    int w;
    w = 0;
    while (((d == 0) ? a_rout : b_rout) !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("idle_wait", 32'(w < 50), 32'(1));
  endtask

  task automatic do_cmd(input int d, input logic [1:0] o, input logic [KW-1:0] k,
                        input logic [TW-1:0] t, input logic ri);
    int w, n;
    bit acc;
    logic [KW-1:0] ok;
    logic [TW-1:0] ot;
    w = 0;
    while (((d == 0) ? a_rout : b_rout) !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_wait", 32'(w < 50), 32'(1));
    ok = (d == 0) ? a_pq : b_pq;
    ot = (d == 0) ? a_tago : b_tago;
    if (d == 0) begin a_data = k; a_tagi = t; a_op = o; a_rin = ri; a_vin = 1'b1; end
    else        begin b_data = k; b_tagi = t; b_op = o; b_rin = ri; b_vin = 1'b1; end
    acc = (w < 50) && ((o == PUSH) || (((o == POP) || (o == REPL)) && ri));
    n = msize(d);
    @(posedge clk); #1;
    if (d == 0) begin a_vin = 1'b0; a_op = NOP; end
    else        begin b_vin = 1'b0; b_op = NOP; end
    if (acc) begin
      case (o)
        PUSH: if (n == D) set_err(d); else mpush(d, k, t);
        POP:  if (n == 0) set_err(d); else mremove(d, ok, ot);
        REPL: if (n == 0) mpush(d, k, t);
              else begin mremove(d, ok, ot); mpush(d, k, t); end
        default: ;
      endcase
    end
  endtask

  // scoreboard compare, every falling edge, both instances
  task automatic check_dut(input int d);
    string p;
    int n;
    logic rout, vout, fl, em, er;
    logic [KW-1:0] pq;
    logic [TW-1:0] tg;
    logic [CW-1:0] cn, hw;
    p    = (d == 0) ? "max" : "min";
    rout = (d == 0) ? a_rout : b_rout;
    vout = (d == 0) ? a_vout : b_vout;
    fl   = (d == 0) ? a_full : b_full;
    em   = (d == 0) ? a_empty : b_empty;
    er   = (d == 0) ? a_err : b_err;
    pq   = (d == 0) ? a_pq : b_pq;
    tg   = (d == 0) ? a_tago : b_tago;
    cn   = (d == 0) ? a_cnt : b_cnt;
    hw   = (d == 0) ? a_hw : b_hw;
    n    = msize(d);
    chk({p, "_count"}, 32'(cn), 32'(n));
    chk({p, "_empty"}, 32'(em), 32'(n == 0));
    chk({p, "_full"},  32'(fl), 32'(n == D));
    chk({p, "_err"},   32'(er), 32'((d == 0) ? experr0 : experr1));
    if (d == 0) experr0 = 1'b0; else experr1 = 1'b0;
    if (!reset) chk({p, "_ready_in_reset"}, 32'(rout), 32'(1));
    if (rout) begin
      chk({p, "_valid"}, 32'(vout), 32'(n != 0));
      chk({p, "_top"},   32'(pq),   32'(top_key(d)));
      if (n != 0) chk({p, "_top_pair"}, 32'(has_pair(d, pq, tg)), 32'(1));
      else        chk({p, "_tag_empty"}, 32'(tg), 32'(0));
    end else begin
      chk({p, "_valid_busy"}, 32'(vout), 32'(0));
      chk({p, "_top_busy"},   32'(pq),   32'(0));
      chk({p, "_tag_busy"},   32'(tg),   32'(0));
    end
`ifdef PQ_HWM_EN
    chk({p, "_high_water"}, 32'(hw), 32'((d == 0) ? hw0 : hw1));
`else
    if (hw !== '0) chk({p, "_hw_tied"}, 32'(hw), 32'(0));
`endif
  endtask

  always @(negedge clk) begin
    check_dut(0);
    check_dut(1);
  end

  initial begin
    logic [KW-1:0] mk [4];
    logic [TW-1:0] mt [4];
    a_data = '0; a_tagi = '0; a_vin = 1'b0; a_op = NOP; a_rin = 1'b1;
    b_data = '0; b_tagi = '0; b_vin = 1'b0; b_op = NOP; b_rin = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(a_rout), 32'(1));
    chk("rst_count", 32'(a_cnt), 32'(0));
    chk("rst_empty", 32'(a_empty), 32'(1));
    chk("rst_valid", 32'(a_vout), 32'(0));
    chk("rst_pq", 32'(a_pq), 32'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // fill
    for (int i = 0; i < 8; i++) begin
      do_cmd(0, PUSH, fill_k[i], 4'(i), 1'b1);
      if (i == 0) chk("push_empty_no_busy", 32'(a_rout), 32'(1));
    end
    wait_idle(0);
    chk("fill_count", 32'(a_cnt), 32'(8));
    chk("fill_full", 32'(a_full), 32'(1));
    chk("fill_top", 32'(a_pq), 32'(8'h8D));

    // overflow
    do_cmd(0, PUSH, 8'h7F, 4'h0, 1'b1);
    chk("ovf_err", 32'(a_err), 32'(1));
    wait_idle(0);
    chk("ovf_count", 32'(a_cnt), 32'(8));
    chk("ovf_top", 32'(a_pq), 32'(8'h8D));

    // drain
    for (int i = 0; i < 8; i++) begin
      wait_idle(0);
      chk($sformatf("drain_%0d", i), 32'(a_pq), 32'(drain_k[i]));
      do_cmd(0, POP, 8'h00, 4'h0, 1'b1);
    end
    wait_idle(0);
    chk("drain_empty", 32'(a_empty), 32'(1));
    chk("drain_valid", 32'(a_vout), 32'(0));
    chk("drain_pq", 32'(a_pq), 32'(0));
    do_cmd(0, POP, 8'h00, 4'h0, 1'b1);
    chk("pop_empty_err", 32'(a_err), 32'(1));

    // replace and backpressure
    do_cmd(0, PUSH, 8'd50, 4'h1, 1'b1);
    do_cmd(0, PUSH, 8'd30, 4'h2, 1'b1);
    do_cmd(0, PUSH, 8'd10, 4'h3, 1'b1);
    do_cmd(0, REPL, 8'd20, 4'h4, 1'b1);
    wait_idle(0);
    chk("repl_top", 32'(a_pq), 32'(8'd30));
    chk("repl_count", 32'(a_cnt), 32'(3));
    for (int i = 0; i < 3; i++) do_cmd(0, POP, 8'h00, 4'h0, 1'b1);
    do_cmd(0, REPL, 8'h42, 4'h5, 1'b1);
    wait_idle(0);
    chk("repl_empty_count", 32'(a_cnt), 32'(1));
    chk("repl_empty_top", 32'(a_pq), 32'(8'h42));
    a_op = POP; a_rin = 1'b0; a_vin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_vin = 1'b0; a_op = NOP; a_rin = 1'b1;
    chk("bp_count", 32'(a_cnt), 32'(1));
    chk("bp_err", 32'(a_err), 32'(0));
    do_cmd(0, POP, 8'h00, 4'h0, 1'b1);

    // min mode
    do_cmd(1, PUSH, 8'd5, 4'd1, 1'b1);
    do_cmd(1, PUSH, 8'd3, 4'd2, 1'b1);
    do_cmd(1, PUSH, 8'd9, 4'd3, 1'b1);
    do_cmd(1, PUSH, 8'd3, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_idle(1);
      mk[i] = b_pq;
      mt[i] = b_tago;
      do_cmd(1, POP, 8'h00, 4'h0, 1'b1);
    end
    chk("min_key0", 32'(mk[0]), 32'(3));
    chk("min_key1", 32'(mk[1]), 32'(3));
    chk("min_key2", 32'(mk[2]), 32'(5));
    chk("min_key3", 32'(mk[3]), 32'(9));
    chk("min_tags_3", 32'((mt[0] == 4'd2 && mt[1] == 4'd4) || (mt[0] == 4'd4 && mt[1] == 4'd2)), 32'(1));
    chk("min_tag_5", 32'(mt[2]), 32'(1));
    chk("min_tag_9", 32'(mt[3]), 32'(3));

    // reset mid-sift
    for (int i = 1; i < 8; i++) do_cmd(0, PUSH, 8'(i), 4'(i), 1'b1);
    wait_idle(0);
    do_cmd(0, PUSH, 8'hF0, 4'hF, 1'b1);
    chk("sift_busy", 32'(a_rout), 32'(0));
    reset = 1'b0;
    mq0.delete(); mq1.delete();
    hw0 = 0; hw1 = 0; experr0 = 1'b0; experr1 = 1'b0;
    #1;
    chk("midrst_count", 32'(a_cnt), 32'(0));
    chk("midrst_empty", 32'(a_empty), 32'(1));
    chk("midrst_valid", 32'(a_vout), 32'(0));
    chk("midrst_ready", 32'(a_rout), 32'(1));
`ifdef PQ_HWM_EN
    chk("midrst_hw", 32'(a_hw), 32'(0));
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    do_cmd(0, PUSH, 8'h11, 4'h1, 1'b1);
    chk("post_rst_top", 32'(a_pq), 32'(8'h11));
`ifdef PQ_HWM_EN
    chk("post_rst_hw", 32'(a_hw), 32'(1));
`endif
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
